incr_pipe_arbiter: RTL
======================

Name: incr_pipe_arbiter

Overview:
- Shares one registered +1 increment chain (STAGES deep, each stage adds 1) between two requesters.
- Round-robin arbitration; tags each issued operand with its requester ID; returns tagged results on a single response port with backpressure.
- Sits in front of the playground increment-chain datapath. Used to exercise nonblocking pipeline sequencing under contention and stall.

Parameters:
- WIDTH, 3, operand/result width in bits; all arithmetic is modulo 2^WIDTH.
- STAGES, 4, number of pipeline registers in the chain (range 1..8); result = operand + STAGES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operand.
- req0_data  input  WIDTH  requester 0 operand.
- req0_ready  output  1  requester 0 operand accepted this cycle when high with req0_valid.
- req1_valid  input  1  requester 1 has an operand.
- req1_data  input  WIDTH  requester 1 operand.
- req1_ready  output  1  requester 1 operand accepted this cycle when high with req1_valid.
- rsp_valid  output  1  result available.
- rsp_id  output  1  requester that issued the result.
- rsp_data  output  WIDTH  result = operand + STAGES mod 2^WIDTH.
- rsp_ready  input  1  consumer accepts result.
- busy  output  1  any pipeline stage holds a valid entry.

Behaviour:
- Reset (rst high at an edge):
  - All stage valid bits clear; rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - Round-robin pointer set so req0 wins the first tie.
  - req0_ready and req1_ready are 0 while rst is high.
  - Reset mid-operation discards all in-flight entries; no response is emitted for them.
- Stall: stall = rsp_valid && !rsp_ready.
  - While stalled, no stage register or valid bit changes, both readies are 0, and rsp_* stay stable.
- Advance: when not stalled, every stage shifts one position per cycle. Stage k holds operand + k (WIDTH-bit wrap), and the shift inserts a bubble when nothing is accepted.
- Arbitration (combinational, evaluated each cycle):
  - Only one valid: grant it.
  - Both valid: grant the requester not granted most recently.
  - reqN_ready = grant_N && !stall && !rst.
  - At most one acceptance per cycle.
  - The pointer updates only on an actual acceptance (valid && ready).
- Latency: an operand accepted in cycle t produces rsp_valid in cycle t+STAGES, provided no stall occurs in between. Each stalled cycle adds one cycle.
- Throughput: one result per cycle with rsp_ready held high.
- Ordering: results return strictly in acceptance order. rsp_id equals the ID of the accepted requester.
- Handshake rules:
  - Requesters hold valid and data stable until ready; a valid may be withdrawn only after its acceptance.
  - rsp_valid/rsp_id/rsp_data hold until rsp_ready.
  - A response is consumed on the cycle rsp_valid && rsp_ready.
- Simultaneous events: a new acceptance and a response consumption in the same cycle are both legal and occur together.
- busy = OR of all stage valid bits, including the output stage.

Optional Feature:
- Macro INCR_PIPE_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (8 bits each).
  - Each increments on its requester's acceptance.
  - Saturates at 255, no wrap.
  - Cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single issue: WIDTH=3, STAGES=4, req0 data=0 accepted cycle 5, rsp_ready=1 -> rsp_valid in cycle 9, rsp_data=4, rsp_id=0, busy high cycles 6-9.
- Wrap: req1 data=5 -> rsp_data=1 (9 mod 8), rsp_id=1.
- Contention: both valid continuously from reset with data 0..7 each -> acceptances alternate 0,1,0,1… starting with req0; responses return in the same order with matching ids, one per cycle.
- Backpressure: rsp_valid with rsp_ready=0 for 3 cycles -> rsp_data/rsp_id frozen, both readies 0 for 3 cycles; pipeline resumes in order with no loss or duplication after rsp_ready=1.
- Reset mid-operation: 3 entries in flight, assert rst one cycle -> next cycle rsp_valid=0, busy=0, no stale result ever emitted; next tie grants req0.
- Stats (INCR_PIPE_ARB_STATS_EN): 300 acceptances from req0 -> grant_cnt0=255, grant_cnt1 unchanged; rst clears both to 0.

Source files
------------

// File: rtl/incr_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// incr_pipe_arbiter
//   Two requesters share one registered +1 increment chain of STAGES stages.
//   A round-robin arbiter picks at most one operand per cycle, tags it with the
//   requester id, and the chain returns operand + STAGES (mod 2^WIDTH) on a
//   single backpressured response port, strictly in acceptance order.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high. Requesters hold valid/data until ready; the response port holds
//   rsp_valid/rsp_id/rsp_data until rsp_ready. The whole chain freezes while
//   rsp_valid && !rsp_ready (stall); during a stall both readies are low.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/data/ready     requester 0 operand handshake
//   req1_valid/data/ready     requester 1 operand handshake
//   rsp_valid/id/data/ready   tagged result handshake
//   busy                      any stage (including the output stage) valid
//   grant_cnt0/1              saturating per-requester acceptance counters,
//                             present only when INCR_PIPE_ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
module incr_pipe_arbiter #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
`ifdef INCR_PIPE_ARB_STATS_EN
  ,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
`endif
);

  // Stage k (0-based) holds operand + k + 1; the last stage is the output.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] id_q, id_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  // Id of the most recent acceptance; reset to 1 so req0 wins the first tie.
  logic              last_q, last_d;

  logic stall;
  logic grant0, grant1;
  logic acc0, acc1, acc;

  assign stall  = vld_q[STAGES-1] && !rsp_ready;
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  assign req0_ready = grant0 && !stall && !rst;
  assign req1_ready = grant1 && !stall && !rst;

  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;
  assign acc  = acc0 || acc1;

  always_comb begin
    vld_d  = vld_q;
    id_d   = id_q;
    data_d = data_q;
    last_d = last_q;
    if (!stall) begin
      vld_d[0]  = acc;
      id_d[0]   = acc1;
      data_d[0] = acc ? ((acc1 ? req1_data : req0_data) + WIDTH'(1)) : '0;
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k]  = vld_q[k-1];
        id_d[k]   = id_q[k-1];
        // Bubbles carry zero so an idle output stage always reads as 0.
        data_d[k] = vld_q[k-1] ? (data_q[k-1] + WIDTH'(1)) : '0;
      end
    end
    if (acc) last_d = acc1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      id_q   <= '0;
      last_q <= 1'b1;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      vld_q  <= vld_d;
      id_q   <= id_d;
      last_q <= last_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign rsp_valid = vld_q[STAGES-1];
  assign rsp_id    = id_q[STAGES-1];
  assign rsp_data  = data_q[STAGES-1];
  assign busy      = |vld_q;

`ifdef INCR_PIPE_ARB_STATS_EN
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (acc0 && (cnt0_q != 8'hff)) cnt0_d = cnt0_q + 8'd1;
    if (acc1 && (cnt1_q != 8'hff)) cnt1_d = cnt1_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule
